deemph_iir: RTL
===============

DEEMPH_IIR -- requirements
Module: deemph_iir

Interface
REQ-001 Parameter DATA_WIDTH, default 32: sample width, two's-complement signed, quantized with BITS fractional bits.
REQ-002 Parameter BITS, default 10: fixed-point fraction bits for coefficients.
REQ-003 Parameter X0, default 178: signed feed-forward coefficient on x[n].
REQ-004 Parameter X1, default 178: signed feed-forward coefficient on x[n-1].
REQ-005 Parameter Y1, default 666: signed feedback coefficient on y[n-1].
REQ-006 clock  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_dout  input  DATA_WIDTH  head word of upstream FIFO (first-word-fall-through, valid while in_empty=0).
REQ-009 in_empty  input  1  upstream FIFO empty.
REQ-010 in_rd_en  output  1  pop upstream FIFO; in_dout consumed in the same cycle.
REQ-011 out_din  output  DATA_WIDTH  filtered sample to downstream FIFO.
REQ-012 out_full  input  1  downstream FIFO full.
REQ-013 out_wr_en  output  1  push out_din into downstream FIFO this cycle.

Function
REQ-014 Block SHALL implement the first-order de-emphasis IIR y[n] = DQ(X0*x[n]) + DQ(X1*x[n-1]) + DQ(Y1*y[n-1]), one output per input, no decimation.
REQ-015 DQ(v) SHALL be arithmetic right shift by BITS rounding toward zero: v>=0 -> v>>>BITS; v<0 -> (v + 2^BITS - 1)>>>BITS.
REQ-016 Products SHALL be formed at 2*DATA_WIDTH signed precision; each DQ result truncated to DATA_WIDTH; the three-term sum SHALL wrap modulo 2^DATA_WIDTH with no saturation.
REQ-017 FSM states: S_IDLE, S_MUL, S_SUM, S_WRITE; encoding free; any unused encoding SHALL return to S_IDLE next cycle.
REQ-018 S_IDLE: when in_empty=0, assert in_rd_en for exactly one cycle, latch in_dout as x[n], go to S_MUL; otherwise stay, in_rd_en=0.
REQ-019 S_MUL: register the three products (X0*x[n], X1*x[n-1], Y1*y[n-1]); go to S_SUM.
REQ-020 S_SUM: register y = sum of the three DQ terms; go to S_WRITE.
REQ-021 S_WRITE: when out_full=0, assert out_wr_en with out_din=y for exactly one cycle, update x[n-1]<=x[n] and y[n-1]<=y, go to S_IDLE; when out_full=1, hold state, y and history unchanged, out_wr_en=0.
REQ-022 out_din SHALL equal the registered y whenever out_wr_en=1; its value when out_wr_en=0 is don't-care but SHALL be driven (no X).
REQ-023 Latency: input popped in cycle t -> out_wr_en earliest in cycle t+3; throughput one sample per 4 cycles with no backpressure.
REQ-024 in_rd_en SHALL never be asserted outside S_IDLE; at most one sample is in flight.
REQ-025 History (x[n-1], y[n-1]) SHALL only change on a successful write.

Reset
REQ-026 On reset=1 at a rising edge: state<=S_IDLE, x[n], x[n-1], y[n-1], products and y cleared to 0.
REQ-027 While reset=1: in_rd_en=0, out_wr_en=0, out_din=0.
REQ-028 Reset asserted in any state SHALL abandon the in-flight sample (no write of it after reset) and clear history.

Verification
REQ-029 Impulse: after reset, feed 1024, 0, 0 -> outputs 178, 293, 190 in order.
REQ-030 Negative impulse: after reset, feed -1024, 0 -> outputs -178, -293 (rounding toward zero).
REQ-031 Backpressure: hold out_full=1 on arrival of first sample 1024 for 10 cycles -> out_wr_en=0 and in_rd_en=0 throughout; on release, single write of 178 next cycle, then next sample accepted.
REQ-032 Timing: in_empty=0 continuously, out_full=0 -> in_rd_en pulses every 4th cycle, each out_wr_en exactly 3 cycles after its in_rd_en.
REQ-033 Reset mid-operation: feed 1024, assert reset in S_SUM, then feed 0 -> no write of 178, next output 0 (history cleared).
REQ-034 Zero input: stream of 0s after reset -> all outputs 0; upstream empty -> no in_rd_en, no out_wr_en.

Source files
------------

// File: rtl/deemph_iir.sv
// First-order de-emphasis IIR between two FWFT FIFOs.
// Ports: clock/reset (sync, active-high), in_* upstream pop side,
//   out_* downstream push side. One output sample per input sample.
//   y[n] = DQ(X0*x[n]) + DQ(X1*x[n-1]) + DQ(Y1*y[n-1])
//   DQ() is an arithmetic shift by BITS that rounds toward zero.
module deemph_iir #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int X0         = 178,
    parameter int X1         = 178,
    parameter int Y1         = 666
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] C_X0 = PW'(X0);
    localparam logic signed [PW-1:0] C_X1 = PW'(X1);
    localparam logic signed [PW-1:0] C_Y1 = PW'(Y1);

    // Bias added to negative products so the shift truncates toward zero.
    localparam logic signed [PW-1:0] RND = (PW'(1) << BITS) - PW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SUM,
        S_WRITE
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  x_q, x_d;
    logic [DATA_WIDTH-1:0]  x1_q, x1_d;
    logic [DATA_WIDTH-1:0]  y1_q, y1_d;
    logic [DATA_WIDTH-1:0]  y_q, y_d;
    logic signed [PW-1:0]   p0_q, p0_d;
    logic signed [PW-1:0]   p1_q, p1_d;
    logic signed [PW-1:0]   p2_q, p2_d;

    function automatic logic signed [PW-1:0] sext(
        input logic [DATA_WIDTH-1:0] v
    );
        return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] dq(
        input logic signed [PW-1:0] v
    );
        logic signed [PW-1:0] adj;
        logic signed [PW-1:0] shr;
        adj = v[PW-1] ? (v + RND) : v;
        shr = adj >>> BITS;
        return shr[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        y_d       = y_q;
        p0_d      = p0_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!in_empty) begin
                    in_rd_en = 1'b1;
                    x_d      = in_dout;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                p0_d    = C_X0 * sext(x_q);
                p1_d    = C_X1 * sext(x1_q);
                p2_d    = C_Y1 * sext(y1_q);
                state_d = S_SUM;
            end
            S_SUM: begin
                // Sum wraps modulo 2^DATA_WIDTH, no saturation.
                y_d     = dq(p0_q) + dq(p1_q) + dq(p2_q);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    x1_d      = x_q;
                    y1_d      = y_q;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshakes stay quiet for the whole reset window.
        if (reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end
    end

    assign out_din = reset ? '0 : y_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            y_q     <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            y_q     <= y_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
        end
    end

endmodule
